// File: rtl/noise_cdf_gen_pkg.sv
// Shared types and defaults for the CDF-driven noise generator.
package noise_cdf_gen_pkg;

    localparam int NUM_BINS_DEF = 128;
    localparam int PROB_W_DEF   = 64;
    localparam int NOISE_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_READY
    } state_t;

    typedef logic [$clog2(NUM_BINS_DEF)-1:0] bin_idx_t;

endpackage

// File: rtl/noise_bsearch_stage.sv
// One step of the MSB-first CDF binary search: probe, compare, register.
module noise_bsearch_stage #(
    parameter int PROB_W = 64,
    parameter int IDX_W  = 7,
    parameter int BIT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PROB_W-1:0] in_rnd,
    input  logic [IDX_W-1:0]  in_idx,
    output logic [IDX_W-1:0]  probe_addr,
    input  logic [PROB_W-1:0] probe_data,
    output logic              out_valid,
    output logic [PROB_W-1:0] out_rnd,
    output logic [IDX_W-1:0]  out_idx
);

    logic [IDX_W-1:0] cand;

    assign cand       = in_idx | (IDX_W'(1) << BIT);
    assign probe_addr = cand - IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rnd   <= '0;
            out_idx   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_rnd   <= in_rnd;
            out_idx   <= (in_rnd >= probe_data) ? cand : in_idx;
        end
    end

endmodule

// File: rtl/noise_cdf_gen.sv
// Uniform random words -> signed noise via a loaded CDF table and pipelined search.
module noise_cdf_gen
    import noise_cdf_gen_pkg::*;
#(
    parameter int NUM_BINS     = NUM_BINS_DEF,
    parameter int PROB_W       = PROB_W_DEF,
    parameter int NOISE_W      = NOISE_W_DEF,
    parameter int NOISE_OFFSET = -63,
    parameter int HIST_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic                        cfg_wr_en,
    input  logic [$clog2(NUM_BINS)-1:0] cfg_addr,
    input  logic [PROB_W-1:0]           cfg_data,
    output logic                        cfg_err,
    output logic                        table_ready,
    input  logic [PROB_W-1:0]           rnd_in,
    input  logic                        rnd_valid,
    output logic                        rnd_ready,
    output logic [NOISE_W-1:0]          noise_out,
    output logic                        noise_valid,
    input  logic                        noise_ready,
    input  logic                        hist_clr,
    input  logic [$clog2(NUM_BINS)-1:0] hist_addr,
    output logic [HIST_W-1:0]           hist_data
);

    localparam int LOG2 = $clog2(NUM_BINS);

    logic [PROB_W-1:0]   cdf [NUM_BINS];
    logic [NUM_BINS-1:0] mask_q, mask_nxt, wr_bit;
    state_t              state_q, state_nxt;
    logic                wr_ok, adv, accept, hs;

    logic              v_p  [LOG2+1];
    logic [PROB_W-1:0] r_p  [LOG2+1];
    logic [LOG2-1:0]   i_p  [LOG2+1];
    logic [LOG2-1:0]   pa_p [LOG2];

    logic [LOG2-1:0]    out_bin;
    logic [NOISE_W-1:0] noise_val;
    logic [HIST_W-1:0]  hist [NUM_BINS];

    assign table_ready = (state_q == ST_READY);
    assign adv         = !noise_valid || noise_ready;
    assign rnd_ready   = table_ready && adv;
    assign accept      = rnd_valid && rnd_ready;
    assign hs          = noise_valid && noise_ready;
    assign wr_ok       = cfg_wr_en && (cfg_start || state_q == ST_LOADING);
    assign wr_bit      = {{(NUM_BINS-1){1'b0}}, 1'b1} << cfg_addr;

    always_comb begin
        mask_nxt  = cfg_start ? '0 : mask_q;
        state_nxt = state_q;
        if (wr_ok) mask_nxt = mask_nxt | wr_bit;
        priority case (1'b1)
            cfg_start:                             state_nxt = ST_LOADING;
            (state_q == ST_LOADING) && &mask_nxt:  state_nxt = ST_READY;
            default:                               state_nxt = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            mask_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mask_q  <= mask_nxt;
            cfg_err <= cfg_wr_en && !wr_ok;
        end
    end

    // Table contents survive reset; the cleared mask forces a reload.
    always_ff @(posedge clk) begin
        if (wr_ok) cdf[cfg_addr] <= cfg_data;
    end

    assign v_p[0] = accept;
    assign r_p[0] = rnd_in;
    assign i_p[0] = '0;

    for (genvar k = 0; k < LOG2; k++) begin : g_stage
        noise_bsearch_stage #(
            .PROB_W (PROB_W),
            .IDX_W  (LOG2),
            .BIT    (LOG2-1-k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (adv),
            .flush      (cfg_start),
            .in_valid   (v_p[k]),
            .in_rnd     (r_p[k]),
            .in_idx     (i_p[k]),
            .probe_addr (pa_p[k]),
            .probe_data (cdf[pa_p[k]]),
            .out_valid  (v_p[k+1]),
            .out_rnd    (r_p[k+1]),
            .out_idx    (i_p[k+1])
        );
    end

    assign noise_val = NOISE_W'(int'(i_p[LOG2]) + NOISE_OFFSET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noise_valid <= 1'b0;
            noise_out   <= '0;
            out_bin     <= '0;
        end else if (cfg_start) begin
            noise_valid <= 1'b0;
        end else if (adv) begin
            noise_valid <= v_p[LOG2];
            if (v_p[LOG2]) begin
                noise_out <= noise_val;
                out_bin   <= i_p[LOG2];
            end
        end
    end

    // Saturating per-bin counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_BINS; j++) hist[j] <= '0;
            hist_data <= '0;
        end else begin
            if (hist_clr) begin
                for (int j = 0; j < NUM_BINS; j++) hist[j] <= '0;
            end else if (hs && hist[out_bin] != '1) begin
                hist[out_bin] <= hist[out_bin] + 1'b1;
            end
            hist_data <= hist[hist_addr];
        end
    end

endmodule
